conv_window_gen: RTL
====================

Name: conv_window_gen

Overview:
- Streaming 3x3 sliding-window generator that feeds the 3x3 convolution datapath.
- Accepts one raster-order pixel per cycle and buffers the two previous image rows in line buffers.
- Presents nine window pixels in the same row-major order as the convolution operands input1..input9, plus a valid strobe.
- Produces "valid" windows only, with no padding: (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMG_WIDTH, 28, pixels per row; legal range is >= 3.
- IMG_HEIGHT, 28, rows per frame; legal range is >= 3.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  clock enable; en=0 stalls the block completely.
- pix_in  input  DATA_WIDTH  incoming pixel, raster order (row-major, top-left first).
- pix_valid  input  1  pix_in is valid this cycle.
- win1..win9  output  DATA_WIDTH each  window pixels, row-major.
  - win1..win3 = row r-2, columns c-2..c.
  - win4..win6 = row r-1, columns c-2..c.
  - win7..win9 = row r, columns c-2..c.
- win_valid  output  1  win1..win9 hold a complete new window (one-cycle strobe per window).
- frame_done  output  1  one-cycle pulse coincident with win_valid for the last window of a frame.

Behaviour:
- Accept condition: accept = en & pix_valid. When accept is 0, no state changes.
- Counters: col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) give the position of the pixel being accepted.
  - col increments on accept.
  - At col = IMG_WIDTH-1, col wraps to 0 and row increments.
  - At row = IMG_HEIGHT-1 and col = IMG_WIDTH-1, both wrap to 0; the next accepted pixel starts a new frame with no gap required.
- Line buffers: two circular buffers, lb0 (row r-1) and lb1 (row r-2), each IMG_WIDTH x DATA_WIDTH and indexed by col. On accept:
  - top = lb1[col], mid = lb0[col];
  - lb1[col] <= lb0[col];
  - lb0[col] <= pix_in.
  - Buffers may be distributed RAM or registers; their contents are not reset.
- Window registers: on accept, every window row shifts left by one column and the new right column is loaded:
  - win1<=win2, win2<=win3, win3<=top;
  - win4<=win5, win5<=win6, win6<=mid;
  - win7<=win8, win8<=win9, win9<=pix_in.
- win_valid: registered, set to accept & (row >= 2) & (col >= 2) using the counters before their update. Latency is 1 cycle from the accepting edge; win outputs and win_valid change on the same edge.
- frame_done: registered, set to accept & (row = IMG_HEIGHT-1) & (col = IMG_WIDTH-1).
- Row boundaries: at col 0 and 1 of each row the window holds stale columns from the previous row's end. win_valid is suppressed there; the window is fully refreshed by col 2.
- First two rows of every frame: win_valid stays 0. Line-buffer data left over from the previous frame is never exposed.
- Outputs hold their values when accept = 0. win_valid and frame_done are 0 in any cycle not following an accept.
- en = 0 with pix_valid = 1: the pixel is dropped and not counted. The source must hold the pixel until en = 1.
- Reset (asynchronous, any time including mid-frame):
  - col, row, win1..win9, win_valid and frame_done clear to 0 immediately.
  - The next accepted pixel is treated as (0,0) of a new frame.
- Arithmetic: no arithmetic on pixel data. Counter widths are $clog2 of IMG_WIDTH and of IMG_HEIGHT, minimum 1 bit.

Test Plan:
- Basic frame (IMG_WIDTH=4, IMG_HEIGHT=4, pixels 1..16 back-to-back):
  - First win_valid appears the cycle after pixel 11, with win1..9 = 1,2,3,5,6,7,9,10,11.
  - Exactly 4 windows are produced.
  - The last window is 6,7,8,10,11,12,14,15,16 with frame_done = 1 on the same cycle only.
- Bubbles: same frame with pix_valid deasserted on random cycles -> identical window sequence; win_valid never high two cycles after a bubble-free accept; outputs hold during gaps.
- Stall: en = 0 for 5 cycles after pixel 7 with pix_valid held at 8 -> no counter advance and outputs frozen. After en returns, windows match the basic-frame case.
- Back-to-back frames: pixels 1..16 then 101..116 with no gap:
  - 8 windows total, frame_done pulses twice.
  - First window of the second frame is 101,102,103,105,106,107,109,110,111, with no window emitted during second-frame rows 0-1.
- Reset mid-frame: assert rst asynchronously (between clock edges) after pixel 9.
  - All outputs go to 0 without waiting for a clock edge.
  - Then feed 1..16: the result equals the basic-frame case exactly.
- Default parameters (28x28, pixel value = (row*28+col) mod 256): 676 windows. Every window is checked against a bench reference model, and frame_done asserts once.

Source files
------------

// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator: raster pixels in, row-major window out.
// Two circular line buffers hold the previous rows. Windows that would need padding are not emitted.
module conv_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_valid,
  output logic [DATA_WIDTH-1:0] win1,
  output logic [DATA_WIDTH-1:0] win2,
  output logic [DATA_WIDTH-1:0] win3,
  output logic [DATA_WIDTH-1:0] win4,
  output logic [DATA_WIDTH-1:0] win5,
  output logic [DATA_WIDTH-1:0] win6,
  output logic [DATA_WIDTH-1:0] win7,
  output logic [DATA_WIDTH-1:0] win8,
  output logic [DATA_WIDTH-1:0] win9,
  output logic                  win_valid,
  output logic                  frame_done
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic                  accept;
  logic [DATA_WIDTH-1:0] top;
  logic [DATA_WIDTH-1:0] mid;

  assign accept = en & pix_valid;
  assign top    = lb1[col];
  assign mid    = lb0[col];

  // Line buffers carry no reset; stale contents are never exposed because
  // win_valid is held low for the first two rows of each frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= pix_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      win1       <= '0;
      win2       <= '0;
      win3       <= '0;
      win4       <= '0;
      win5       <= '0;
      win6       <= '0;
      win7       <= '0;
      win8       <= '0;
      win9       <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= accept && (row >= ROW_TWO) && (col >= COL_TWO);
      frame_done <= accept && (row == ROW_LAST) && (col == COL_LAST);
      if (accept) begin
        win1 <= win2;
        win2 <= win3;
        win3 <= top;
        win4 <= win5;
        win5 <= win6;
        win6 <= mid;
        win7 <= win8;
        win8 <= win9;
        win9 <= pix_in;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule
